// File: rtl/edit_sequencer_pkg.sv
// Shared scan-code constants and FSM state encoding for the edit sequencer.
package edit_sequencer_pkg;

  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_ESC   = 8'h76;
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_BREAK = 8'hF0;
  localparam logic [7:0] KEY_EXT   = 8'hE0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EDIT = 1'b1
  } state_t;

endpackage

// File: rtl/edit_sequencer_ps2_key_filter.sv
// PS/2 make/break filter: drops EXT prefixes and released keys, leaving
// a one-cycle key event qualified by the incoming got_data strobe.
module ps2_key_filter
  import edit_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_cambio,
  input  logic       i_got_data,
  output logic       o_key_valid,
  output logic [7:0] o_key_code
);

  logic r_break;

  // EXT leaves the flag alone; any other byte either arms it (BREAK) or
  // consumes it (the released key code).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_break <= 1'b0;
    else if (i_got_data && (i_cambio != KEY_EXT))
      r_break <= (i_cambio == KEY_BREAK);
  end

  assign o_key_valid = i_got_data && !r_break &&
                       (i_cambio != KEY_EXT) && (i_cambio != KEY_BREAK);
  assign o_key_code  = i_cambio;

endmodule

// File: rtl/edit_sequencer.sv
// Edit-mode sequencer: turns PS/2 key events into field select and
// inc/dec/commit/cancel strobes. EDIT_TIMEOUT_EN adds idle auto-cancel.
module edit_sequencer
  import edit_sequencer_pkg::*;
#(
  parameter int              NUM_FIELDS  = 3,
  parameter int              SEL_W       = 2,
  parameter logic [31:0]     TIMEOUT_CYC = 32'd500_000_000,
  parameter int              TO_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            Cambio,
  input  logic                  got_data,
  output logic                  edit_mode,
  output logic [SEL_W-1:0]      sel,
  output logic [NUM_FIELDS-1:0] inc,
  output logic [NUM_FIELDS-1:0] dec,
  output logic                  commit,
  output logic                  cancel
);

  logic                  w_key_valid;
  logic [7:0]            w_key_code;
  state_t                r_state;
  logic [SEL_W-1:0]      r_sel;
  logic [NUM_FIELDS-1:0] r_inc;
  logic [NUM_FIELDS-1:0] r_dec;
  logic                  r_commit;
  logic                  r_cancel;

  ps2_key_filter u_filter (
    .clk         (clk),
    .rst         (rst),
    .i_cambio    (Cambio),
    .i_got_data  (got_data),
    .o_key_valid (w_key_valid),
    .o_key_code  (w_key_code)
  );

`ifdef EDIT_TIMEOUT_EN
  logic [TO_W-1:0] r_to;
`else
  logic w_unused_to;
  assign w_unused_to = (|TIMEOUT_CYC) ^ (TO_W == 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_sel    <= '0;
      r_inc    <= '0;
      r_dec    <= '0;
      r_commit <= 1'b0;
      r_cancel <= 1'b0;
`ifdef EDIT_TIMEOUT_EN
      r_to     <= '0;
`endif
    end else begin
      r_inc    <= '0;
      r_dec    <= '0;
      r_commit <= 1'b0;
      r_cancel <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_key_valid && (w_key_code == KEY_ENTER)) begin
            r_state <= ST_EDIT;
            r_sel   <= '0;
`ifdef EDIT_TIMEOUT_EN
            r_to    <= '0;
`endif
          end
        end
        ST_EDIT: begin
          // A key event wins over a coincident timeout expiry.
          if (w_key_valid) begin
`ifdef EDIT_TIMEOUT_EN
            r_to <= '0;
`endif
            case (w_key_code)
              KEY_UP: begin
                for (int i = 0; i < NUM_FIELDS; i++)
                  r_inc[i] <= (r_sel == SEL_W'(i));
              end
              KEY_DOWN: begin
                for (int i = 0; i < NUM_FIELDS; i++)
                  r_dec[i] <= (r_sel == SEL_W'(i));
              end
              // Explicit wrap compare: NUM_FIELDS need not be a power of 2.
              KEY_LEFT:
                r_sel <= (r_sel == SEL_W'(NUM_FIELDS-1)) ? '0 : r_sel + 1'b1;
              KEY_RIGHT:
                r_sel <= (r_sel == '0) ? SEL_W'(NUM_FIELDS-1) : r_sel - 1'b1;
              KEY_ENTER: begin
                r_commit <= 1'b1;
                r_state  <= ST_IDLE;
                r_sel    <= '0;
              end
              KEY_ESC: begin
                r_cancel <= 1'b1;
                r_state  <= ST_IDLE;
                r_sel    <= '0;
              end
              default: ;
            endcase
          end
`ifdef EDIT_TIMEOUT_EN
          else if (r_to == TO_W'(TIMEOUT_CYC - 32'd1)) begin
            r_cancel <= 1'b1;
            r_state  <= ST_IDLE;
            r_sel    <= '0;
            r_to     <= '0;
          end else begin
            r_to <= r_to + 1'b1;
          end
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign edit_mode = (r_state == ST_EDIT);
  assign sel       = r_sel;
  assign inc       = r_inc;
  assign dec       = r_dec;
  assign commit    = r_commit;
  assign cancel    = r_cancel;

endmodule

// File: tb/tb_edit_sequencer.sv
// Directed + random bench for edit_sequencer against a key-level reference model.
module tb_edit_sequencer;
  localparam int NF = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] Cambio = 8'h00;
  logic       got_data = 1'b0;
  logic       edit_mode, commit, cancel;
  logic [1:0] sel;
  logic [2:0] inc, dec;

  int total = 0;
  int passed = 0;

  // reference model state and expected outputs
  bit       m_edit;
  int       m_sel;
  bit       m_brk;
  bit [2:0] e_inc, e_dec;
  bit       e_commit, e_cancel;

  edit_sequencer dut (
    .clk(clk), .rst(rst), .Cambio(Cambio), .got_data(got_data),
    .edit_mode(edit_mode), .sel(sel), .inc(inc), .dec(dec),
    .commit(commit), .cancel(cancel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".edit_mode"}, 32'(edit_mode), 32'(m_edit));
    chk({tag, ".sel"},       32'(sel),       32'(m_sel));
    chk({tag, ".inc"},       32'(inc),       32'(e_inc));
    chk({tag, ".dec"},       32'(dec),       32'(e_dec));
    chk({tag, ".commit"},    32'(commit),    32'(e_commit));
    chk({tag, ".cancel"},    32'(cancel),    32'(e_cancel));
  endtask

  function automatic void model_reset();
    m_edit = 0; m_sel = 0; m_brk = 0;
    e_inc = 0; e_dec = 0; e_commit = 0; e_cancel = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (b == 8'hE0) return;
    if (b == 8'hF0) begin m_brk = 1; return; end
    if (m_brk) begin m_brk = 0; return; end
    if (!m_edit) begin
      if (b == 8'h5A) begin m_edit = 1; m_sel = 0; end
      return;
    end
    case (b)
      8'h75: e_inc = 3'(1 << m_sel);
      8'h72: e_dec = 3'(1 << m_sel);
      8'h6B: m_sel = (m_sel + 1) % NF;
      8'h74: m_sel = (m_sel + NF - 1) % NF;
      8'h5A: begin e_commit = 1; m_edit = 0; m_sel = 0; end
      8'h76: begin e_cancel = 1; m_edit = 0; m_sel = 0; end
      default: ;
    endcase
  endfunction

  // called right after a negedge; outputs checked at the following negedge
  task automatic send(input logic [7:0] b, input bit gd, input string tag);
    Cambio = b; got_data = gd;
    e_inc = 0; e_dec = 0; e_commit = 0; e_cancel = 0;
    if (gd) model_byte(b);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) send(8'h00, 1'b0, tag);
  endtask

  logic [7:0] codes [10];

  initial begin
    codes = '{8'h5A, 8'h76, 8'h75, 8'h72, 8'h6B, 8'h74, 8'hF0, 8'hE0, 8'h75, 8'h6B};
    model_reset();
    @(negedge clk);
    check_all("reset");
    rst = 1'b1;
    idle(2, "post_reset");

    // enter and count on field 0
    send(8'h5A, 1, "enter");
    send(8'h75, 1, "up0a");
    send(8'h75, 1, "up0b");
    send(8'h72, 1, "down0");
    idle(1, "gap1");

    // selection wrap both ways
    send(8'h6B, 1, "left1");
    send(8'h6B, 1, "left2");
    send(8'h6B, 1, "left_wrap");
    send(8'h74, 1, "right_wrap");
    send(8'h75, 1, "up2");

    // release is swallowed, extended make counts once
    send(8'hF0, 1, "brk");
    send(8'h75, 1, "release_up");
    send(8'hE0, 1, "ext");
    send(8'h75, 1, "ext_up");
    idle(1, "gap2");

    send(8'h5A, 1, "commit");
    idle(1, "after_commit");
    send(8'h5A, 1, "reenter");
    send(8'h76, 1, "esc");
    idle(1, "after_cancel");

    // idle ignores nav keys; ENTER release must not enter EDIT
    send(8'h75, 1, "idle_up");
    send(8'h72, 1, "idle_down");
    send(8'h6B, 1, "idle_left");
    send(8'hF0, 1, "idle_brk");
    send(8'h5A, 1, "idle_enter_rel");
    idle(1, "gap3");

    // EDIT persists through a long idle stretch
    send(8'h5A, 1, "enter_long");
    idle(40, "long_idle");
    send(8'h6B, 1, "long_left");

    // async reset mid-edit, with an inc pulse outstanding
    send(8'h75, 1, "pre_rst_up");
    #2 rst = 1'b0;
    model_reset();
    #1 check_all("async_rst");
    @(negedge clk);
    check_all("rst_held");
    rst = 1'b1;
    idle(1, "rst_release");

    // random byte stream, got_data on roughly 3/4 of cycles
    for (int i = 0; i < 600; i++) begin
      logic [7:0] b;
      if ($urandom_range(0, 7) == 0) b = 8'($urandom);
      else b = codes[$urandom_range(0, 9)];
      send(b, ($urandom_range(0, 3) != 0), "rand");
    end
    idle(1, "final");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/edit_sequencer.md
Name: edit_sequencer

Overview:
- Sequences manual time-setting from PS/2 scan codes and drives the per-field up/down counters (seconds/minutes/hours) one field at a time.
- Sits between the PS/2 receiver (scan code + got_data strobe) and the field counters plus the time-register write logic.
- Owns the edit-mode FSM, field selection, make/break filtering, and commit/cancel strobes.

Parameters:
- NUM_FIELDS, 3, number of editable fields; field 0 = seconds, increasing index = more significant field.
- SEL_W, 2, width of the field index; must satisfy 2**SEL_W >= NUM_FIELDS.
- TIMEOUT_CYC, 32'd500_000_000, idle cycles in EDIT before auto-cancel (optional feature only).
- TO_W, 32, width of the timeout counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- Cambio  in  8  scan code from the PS/2 receiver; valid only when got_data=1.
- got_data  in  1  one-cycle strobe: Cambio holds a new byte.
- edit_mode  out  1  1 while in EDIT; drives display blinking.
- sel  out  SEL_W  index of the field currently being edited.
- inc  out  NUM_FIELDS  one-hot, one-cycle increment pulse to the selected field counter.
- dec  out  NUM_FIELDS  one-hot, one-cycle decrement pulse to the selected field counter.
- commit  out  1  one-cycle pulse: load edited values into the time register.
- cancel  out  1  one-cycle pulse: field counters reload from the time register.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, edit_mode=0, sel=0, inc=0, dec=0, commit=0, cancel=0, break_flag=0, timeout counter=0.
- Key codes: ENTER 8'h5A, ESC 8'h76, UP 8'h75, DOWN 8'h72, LEFT 8'h6B, RIGHT 8'h74, BREAK 8'hF0, EXT 8'hE0.
- Byte filter, applied on every got_data:
  - EXT is ignored and leaves break_flag unchanged.
  - BREAK sets break_flag.
  - Any other byte with break_flag=1 clears break_flag and is discarded (key release).
  - Any other byte with break_flag=0 is a "key event".
- All outputs are registered. A pulse is high exactly in the cycle after the got_data edge that carries the key, and lasts one cycle. No pulses occur while got_data=0.
- FSM states: IDLE and EDIT.
- IDLE:
  - ENTER event: go to EDIT, sel=0, edit_mode=1.
  - All other events are ignored; inc, dec, commit and cancel stay 0.
- EDIT:
  - UP: inc[sel]=1 for one cycle.
  - DOWN: dec[sel]=1 for one cycle.
  - LEFT: sel = sel+1; wraps from NUM_FIELDS-1 to 0.
  - RIGHT: sel = sel-1; wraps from 0 to NUM_FIELDS-1.
  - ENTER: commit=1 for one cycle, go to IDLE, edit_mode=0, sel=0.
  - ESC: cancel=1 for one cycle, go to IDLE, edit_mode=0, sel=0.
  - Unlisted codes are ignored.
- inc and dec are never both nonzero. At most one bit of each is set, and it always matches the pre-event sel.
- Selection change and count pulse never coincide, because each byte is one event.
- Arithmetic: sel wrap is compared against NUM_FIELDS-1 explicitly, not by natural overflow, since NUM_FIELDS need not be a power of 2.
- Reset asserted mid-edit: immediate return to IDLE with no commit and no cancel pulse.
- A break prefix received in IDLE still arms break_flag, so a later ENTER release never enters EDIT.
- got_data asserted on consecutive cycles is legal; each byte is processed in order.

Optional Feature:
- Macro: EDIT_TIMEOUT_EN.
- Defined:
  - A TO_W counter clears on entering EDIT and on every key event in EDIT, and increments each cycle in EDIT.
  - When it reaches TIMEOUT_CYC-1: cancel=1 for one cycle, go to IDLE, sel=0, counter=0.
  - A key event in the same cycle as expiry takes priority; the timeout is then discarded.
- Undefined: no counter logic; EDIT persists until ENTER or ESC.

Decomposition:
- Shared package: scan-code constants (KEY_ENTER, KEY_ESC, KEY_UP, KEY_DOWN, KEY_LEFT, KEY_RIGHT, KEY_BREAK, KEY_EXT) and the FSM state encoding (ST_IDLE=1'b0, ST_EDIT=1'b1).
- One sub-module: ps2_key_filter. It takes Cambio/got_data and outputs key_valid (one-cycle) plus key_code, implementing the break/EXT filtering. The FSM consumes only key_valid/key_code.

Test Plan:
- Reset, then bytes 5A, 75, 75, 72 -> edit_mode=1, sel=0; inc=3'b001 twice, then dec=3'b001, each one cycle wide, one cycle after its got_data.
- In EDIT: 6B, 6B, 6B, then 74 -> sel goes 1, 2, 0 (wrap), then 2 (wrap down); 75 -> inc=3'b100.
- In EDIT: F0 75 (release) -> no inc pulse; then E0 75 (extended make) -> inc[sel]=1 exactly once.
- In EDIT: 5A -> commit=1 for one cycle, edit_mode=0, sel=0. Re-enter, press 76 -> cancel=1 for one cycle, commit stays 0.
- In IDLE: 75, 72, 6B -> no outputs change. Assert rst=0 asynchronously mid-EDIT -> all outputs 0 immediately, without a clock edge.
- With EDIT_TIMEOUT_EN and TIMEOUT_CYC=16: enter EDIT, idle 16 cycles -> cancel pulse, IDLE. A key at cycle 10 restarts the count.
